// File: rtl/hydra_pkg.sv
// Shared constants and types for the ingress page packer.
// Bank states and sealed-page metadata live here.
package hydra_pkg;

  localparam int DATA_W     = 16;
  localparam int PAGE_WORDS = 8;
  localparam int PORT_W     = 4;
  localparam int PRIO_W     = 3;
  localparam int IDX_W      = $clog2(PAGE_WORDS);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  len;
    logic              first;
    logic              last;
    logic [PORT_W-1:0] dest;
    logic [PRIO_W-1:0] prior;
  } page_meta_t;

endpackage

// File: rtl/page_bank.sv
// One page buffer: word array, sealed metadata and fill state.
// Freeing a bank clears its words so short pages read 0 above len.
module page_bank
  import hydra_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_i,
  input  logic [IDX_W-1:0]             idx_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         seal_i,
  input  page_meta_t                   meta_i,
  input  logic                         free_i,
  output logic [DATA_W*PAGE_WORDS-1:0] data_o,
  output page_meta_t                   meta_o,
  output bank_state_t                  state_o
);

  logic [DATA_W-1:0] mem_q [PAGE_WORDS];
  page_meta_t        meta_q;
  bank_state_t       state_q;

  // Store words, capture metadata on seal, clear on free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAGE_WORDS; i++) mem_q[i] <= '0;
      meta_q  <= '0;
      state_q <= EMPTY;
    end else if (free_i) begin
      for (int i = 0; i < PAGE_WORDS; i++) mem_q[i] <= '0;
      meta_q  <= '0;
      state_q <= EMPTY;
    end else if (wr_i) begin
      mem_q[idx_i] <= data_i;
      state_q      <= seal_i ? FULL : FILLING;
      if (seal_i) meta_q <= meta_i;
    end
  end

  // Flatten the word array onto the page bus
  always_comb begin
    data_o = '0;
    for (int i = 0; i < PAGE_WORDS; i++)
      data_o[i*DATA_W +: DATA_W] = mem_q[i];
  end

  assign meta_o  = meta_q;
  assign state_o = state_q;

endmodule

// File: rtl/page_packer.sv
// Packs the parser word stream into 8-word tagged pages.
// Two ping-pong banks absorb writer stalls; overflow drops the packet.
module page_packer
  import hydra_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_page_end,
  input  logic                         in_pkt_end,
  input  logic [PORT_W-1:0]            in_dest,
  input  logic [PRIO_W-1:0]            in_prior,
  output logic                         pg_vld,
  input  logic                         pg_rdy,
  output logic [DATA_W*PAGE_WORDS-1:0] pg_data,
  output logic [IDX_W-1:0]             pg_len,
  output logic                         pg_first,
  output logic                         pg_last,
  output logic [PORT_W-1:0]            pg_dest,
  output logic [PRIO_W-1:0]            pg_prior,
  output logic                         drop_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_WORDS-1);

  logic              fill_q, fill_d;
  logic              out_q, out_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              first_q, first_d;
  logic              drop_q, drop_d;
  logic              derr_q, derr_d;
  logic              vld_q, vld_d;
  logic [PORT_W-1:0] dest_q, dest_d;
  logic [PRIO_W-1:0] prior_q, prior_d;

  logic [DATA_W*PAGE_WORDS-1:0] bdata [2];
  page_meta_t                   bmeta [2];
  bank_state_t                  bst   [2];

  logic              fill_full, xfer, wr, drop_now;
  logic              seal, capt;
  logic [PORT_W-1:0] tag_dest;
  logic [PRIO_W-1:0] tag_prior;
  page_meta_t        meta_w, meta_o;

  // Classify the incoming word: write, seal or drop
  always_comb begin
    fill_full = (bst[fill_q] == FULL);
    xfer      = vld_q && pg_rdy;
    wr        = in_vld && !drop_q && !fill_full;
    drop_now  = in_vld && !drop_q && fill_full;
    seal      = wr && (in_page_end || in_pkt_end ||
                       idx_q == LAST_IDX);
    capt      = first_q && (idx_q == '0);
    tag_dest  = capt ? in_dest : dest_q;
    tag_prior = capt ? in_prior : prior_q;
    meta_w    = '{len:   idx_q,
                  first: first_q,
                  last:  in_pkt_end,
                  dest:  tag_dest,
                  prior: tag_prior};
  end

  // Next-state for pointers, index, tags, drop mode, offer
  always_comb begin
    fill_d  = fill_q;
    out_d   = out_q;
    idx_d   = idx_q;
    first_d = first_q;
    drop_d  = drop_q;
    dest_d  = tag_dest;
    prior_d = tag_prior;
    derr_d  = drop_now;
    if (seal) begin
      fill_d  = ~fill_q;
      idx_d   = '0;
      first_d = in_pkt_end;
    end else if (wr) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if (drop_now) begin
      drop_d  = !in_pkt_end;
      first_d = 1'b1;
    end else if (drop_q && in_vld && in_pkt_end) begin
      drop_d = 1'b0;
    end
    if (xfer) out_d = ~out_q;
    // One idle cycle follows every transfer
    vld_d = !xfer && ((bst[out_q] == FULL) ||
                      (seal && fill_q == out_q));
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= 1'b0;
      out_q   <= 1'b0;
      idx_q   <= '0;
      first_q <= 1'b1;
      drop_q  <= 1'b0;
      derr_q  <= 1'b0;
      vld_q   <= 1'b0;
      dest_q  <= '0;
      prior_q <= '0;
    end else begin
      fill_q  <= fill_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      drop_q  <= drop_d;
      derr_q  <= derr_d;
      vld_q   <= vld_d;
      dest_q  <= dest_d;
      prior_q <= prior_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    page_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (wr && (fill_q == 1'(g))),
      .idx_i   (idx_q),
      .data_i  (in_data),
      .seal_i  (seal),
      .meta_i  (meta_w),
      .free_i  (xfer && (out_q == 1'(g))),
      .data_o  (bdata[g]),
      .meta_o  (bmeta[g]),
      .state_o (bst[g])
    );
  end

  assign meta_o   = bmeta[out_q];
  assign pg_vld   = vld_q;
  assign pg_data  = bdata[out_q];
  assign pg_len   = meta_o.len;
  assign pg_first = meta_o.first;
  assign pg_last  = meta_o.last;
  assign pg_dest  = meta_o.dest;
  assign pg_prior = meta_o.prior;
  assign drop_err = derr_q;

endmodule
